// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
package muldiv_pkg;

   // Operation select, matches the encoding on the op port
   typedef enum logic [1:0] {
      OP_MUL  = 2'b00,   // low half of product
      OP_MULH = 2'b01,   // high half of product
      OP_DIV  = 2'b10,   // unsigned quotient
      OP_MOD  = 2'b11    // unsigned remainder
   } op_e;

   // Controller states
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_e;

   // Divide ops have op[1] set; they share the datapath with multiply
   function automatic logic is_div(input op_e op);
      return op[1];
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit, one operand bit per cycle.
// A single {r_hi, r_lo} shift pair serves both algorithms:
//   MUL/MULH : r_lo starts as multiplier, r_opnd is multiplicand,
//              shift-add moves the product into {r_hi, r_lo}.
//   DIV/MOD  : r_lo starts as dividend, r_opnd is divisor,
//              restoring divide leaves quotient in r_lo, remainder in r_hi.
// A zero divisor never borrows, so quotient becomes all-ones and the
// remainder ends up equal to the dividend with no special casing.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [1:0]       dst_addr,
   input  logic [WIDTH-1:0] rd_data,
   input  logic [WIDTH-1:0] rs_data,
   output logic             busy,
   output logic             w_en,
   output logic [1:0]       w_addr,
   output logic [WIDTH-1:0] w_data
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           r_state, w_state_nxt;
   op_e              r_op;
   logic [1:0]       r_dst;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_opnd;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   logic             w_accept;
   logic             w_last;
   logic [WIDTH:0]   w_mul_sum;
   logic [WIDTH:0]   w_div_sh;
   logic [WIDTH+1:0] w_div_diff;
   logic             w_div_borrow;
   logic [WIDTH-1:0] w_result;

   assign w_accept = (r_state == S_IDLE) && start;
   assign w_last   = (r_cnt == LAST);

   // Per-cycle datapath step for both algorithms
   always_comb begin
      w_mul_sum    = {1'b0, r_hi};
      if (r_lo[0])
         w_mul_sum = {1'b0, r_hi} + {1'b0, r_opnd};
      // bring next dividend bit into the partial remainder, then trial subtract
      w_div_sh     = {r_hi, r_lo[WIDTH-1]};
      w_div_diff   = {1'b0, w_div_sh} - {2'b00, r_opnd};
      w_div_borrow = w_div_diff[WIDTH+1];
   end

   // Result select; both halves are already in place after WIDTH steps
   always_comb begin
      w_result = r_lo;
      case (r_op)
         OP_MUL:  w_result = r_lo;
         OP_MULH: w_result = r_hi;
         OP_DIV:  w_result = r_lo;
         OP_MOD:  w_result = r_hi;
         default: w_result = r_lo;
      endcase
   end

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Next state and state-decoded outputs; write-back only visible in DONE
   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      w_en        = 1'b0;
      w_addr      = 2'b00;
      w_data      = '0;
      case (r_state)
         S_IDLE: begin
            if (start)
               w_state_nxt = S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (w_last)
               w_state_nxt = S_DONE;
         end
         S_DONE: begin
            busy        = 1'b1;
            w_en        = 1'b1;
            w_addr      = r_dst;
            w_data      = w_result;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Operand latch and iteration; start is only honoured from IDLE
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_op   <= OP_MUL;
         r_dst  <= 2'b00;
         r_cnt  <= '0;
         r_opnd <= '0;
         r_hi   <= '0;
         r_lo   <= '0;
      end else if (w_accept) begin
         r_op   <= op_e'(op);
         r_dst  <= dst_addr;
         r_cnt  <= '0;
         r_hi   <= '0;
         if (op[1]) begin
            r_opnd <= rs_data;   // divisor
            r_lo   <= rd_data;   // dividend
         end else begin
            r_opnd <= rd_data;   // multiplicand
            r_lo   <= rs_data;   // multiplier
         end
      end else if (r_state == S_RUN) begin
         r_cnt <= r_cnt + 1'b1;
         if (is_div(r_op)) begin
            if (w_div_borrow)
               r_hi <= w_div_sh[WIDTH-1:0];
            else
               r_hi <= w_div_diff[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], ~w_div_borrow};
         end else begin
            {r_hi, r_lo} <= {w_mul_sum, r_lo[WIDTH-1:1]};
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=8).
// Latency is counted in falling edges after the accepting rising edge:
// the first falling edge after acceptance is 1, w_en must appear at 9.
module tb_muldiv_unit;

   localparam int WIDTH = 8;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic [1:0]       op = 2'b00;
   logic [1:0]       dst_addr = 2'b00;
   logic [WIDTH-1:0] rd_data = '0;
   logic [WIDTH-1:0] rs_data = '0;
   logic             busy;
   logic             w_en;
   logic [1:0]       w_addr;
   logic [WIDTH-1:0] w_data;

   int n_chk = 0;
   int n_err = 0;

   muldiv_unit #(.WIDTH(WIDTH)) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .dst_addr (dst_addr),
      .rd_data  (rd_data),
      .rs_data  (rs_data),
      .busy     (busy),
      .w_en     (w_en),
      .w_addr   (w_addr),
      .w_data   (w_data)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one op and watch 14 falling edges: latency, data, address,
   // pulse count, and zeroed outputs outside the pulse.
   // restart=1 re-asserts start with other operands during RUN.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [1:0] d,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_d, input bit restart);
      int lat = 0, pulses = 0, leak = 0;
      logic [7:0] got_d = '0;
      logic [1:0] got_a = '0;
      @(negedge clock);
      op = o; dst_addr = d; rd_data = a; rs_data = b; start = 1'b1;
      @(posedge clock);
      for (int n = 1; n <= 14; n++) begin
         @(negedge clock);
         if (n == 1) begin
            start = 1'b0;
            chk({tag, "_busy"}, busy, 1'b1);
         end
         if (restart && n == 3) begin
            op = ~o; dst_addr = ~d; rd_data = ~a; rs_data = b + 8'd1; start = 1'b1;
         end
         if (restart && n == 5)
            start = 1'b0;
         if (w_en) begin
            pulses++;
            if (lat == 0) lat = n;
            got_d = w_data;
            got_a = w_addr;
         end else if (w_data != 0 || w_addr != 0) begin
            leak++;
         end
      end
      chk({tag, "_lat"}, lat, 9);
      chk({tag, "_pulses"}, pulses, 1);
      chk({tag, "_data"}, got_d, exp_d);
      chk({tag, "_addr"}, got_a, d);
      chk({tag, "_idle0"}, leak, 0);
      chk({tag, "_busy_end"}, busy, 1'b0);
   endtask

   initial begin
      int wr;
      // reset state
      #12;
      chk("rst_busy", busy, 1'b0);
      chk("rst_wen", w_en, 1'b0);
      chk("rst_waddr", w_addr, 2'b00);
      chk("rst_wdata", w_data, 8'h00);
      @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      chk("idle_stays", busy, 1'b0);

      // 13*11 = 143 = 0x008F
      run_op("mul13x11",  2'b00, 2'd1, 8'd13,  8'd11, 8'h8F, 1'b0);
      run_op("mulh13x11", 2'b01, 2'd2, 8'd13,  8'd11, 8'h00, 1'b0);
      // 200*3 = 600 = 0x0258
      run_op("mul200x3",  2'b00, 2'd3, 8'd200, 8'd3,  8'h58, 1'b0);
      run_op("mulh200x3", 2'b01, 2'd1, 8'd200, 8'd3,  8'h02, 1'b0);
      // 200 / 7 = 28 rem 4
      run_op("div200x7",  2'b10, 2'd2, 8'd200, 8'd7,  8'h1C, 1'b0);
      run_op("mod200x7",  2'b11, 2'd3, 8'd200, 8'd7,  8'h04, 1'b0);
      // divide by zero
      run_op("div0",      2'b10, 2'd0, 8'h55,  8'h00, 8'hFF, 1'b0);
      run_op("mod0",      2'b11, 2'd1, 8'h55,  8'h00, 8'h55, 1'b0);
      // 255*255 = 65025 = 0xFE01
      run_op("mulhmax",   2'b01, 2'd2, 8'hFF,  8'hFF, 8'hFE, 1'b0);
      // restart during RUN is ignored
      run_op("restart",   2'b00, 2'd2, 8'd13,  8'd11, 8'h8F, 1'b1);

      // reset mid-RUN at cycle 4
      @(negedge clock);
      op = 2'b00; dst_addr = 2'd3; rd_data = 8'd13; rs_data = 8'd11; start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      repeat (3) @(negedge clock);
      chk("abort_busy_pre", busy, 1'b1);
      reset = 1'b1;
      #1;
      chk("abort_busy", busy, 1'b0);
      chk("abort_wen", w_en, 1'b0);
      @(negedge clock);
      reset = 1'b0;
      wr = 0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clock);
         if (w_en) wr++;
      end
      chk("abort_nowb", wr, 0);
      run_op("post_abort", 2'b10, 2'd1, 8'd200, 8'd7, 8'h1C, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   // global time bound
   initial begin
      #200000;
      $display("FAIL timeout got 1 want 0");
      $fatal(1);
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand, result and register data width.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin an operation.
REQ-005 SHALL have port op, input, 2, operation select: 00 MUL (low byte), 01 MULH (high byte), 10 DIV (quotient), 11 MOD (remainder).
REQ-006 SHALL have port dst_addr, input, 2, destination register index to be written back.
REQ-007 SHALL have port rd_data, input, WIDTH, first operand from the register-file rd port: multiplicand or dividend.
REQ-008 SHALL have port rs_data, input, WIDTH, second operand from the register-file rs port: multiplier or divisor.
REQ-009 SHALL have port busy, output, 1, high whenever the unit is not IDLE.
REQ-010 SHALL have port w_en, output, 1, register-file write enable pulse.
REQ-011 SHALL have port w_addr, output, 2, register-file write index.
REQ-012 SHALL have port w_data, output, WIDTH, register-file write data.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 SHALL, in IDLE with start=1 at a rising edge, latch op, dst_addr, rd_data and rs_data, clear iteration counter, and enter RUN.
REQ-015 SHALL, in IDLE with start=0, remain in IDLE.
REQ-016 SHALL ignore start while in RUN or DONE: no relatch and no restart.
REQ-017 SHALL process one operand bit per cycle in RUN, using shift-add multiply or restoring divide, for exactly WIDTH cycles, then enter DONE.
REQ-018 SHALL produce the full 2*WIDTH-bit product; MUL returns bits [WIDTH-1:0] and MULH returns bits [2*WIDTH-1:WIDTH], both unsigned.
REQ-019 SHALL produce an unsigned quotient for DIV and an unsigned remainder for MOD.
REQ-020 SHALL, on divisor zero, return quotient all-ones and remainder equal to the dividend, with unchanged latency.
REQ-021 SHALL, in DONE, assert w_en=1 for exactly one cycle, drive w_addr with the latched dst_addr and w_data with the selected result, then return to IDLE.
REQ-022 SHALL assert w_en exactly WIDTH+1 cycles after the edge that accepted start (9 cycles for WIDTH=8).
REQ-023 SHALL allow a new start to be accepted on the edge that leaves DONE only if it is sampled in the following IDLE cycle, giving a minimum issue interval of WIDTH+2 cycles.
REQ-024 SHALL hold w_en=0, w_addr=0 and w_data=0 whenever not in DONE.
REQ-025 SHALL drive busy combinationally from state: 1 in RUN and DONE, 0 in IDLE.

Reset
REQ-026 SHALL, on reset assertion at any time including mid-RUN or in DONE, immediately enter IDLE and clear counter, operand, accumulator and latched fields.
REQ-027 SHALL hold busy=0, w_en=0, w_addr=0 and w_data=0 while reset is high, and SHALL NOT produce any write-back for an aborted operation.

Structure
REQ-028 SHALL place the op encodings (MUL, MULH, DIV, MOD) and the FSM state type in a shared package muldiv_pkg.
REQ-029 SHALL be implemented as one module with FSM, counter and shared shift datapath; no sub-module is required.

Verification
REQ-030 SHALL test MUL and MULH with rd=13, rs=11 -> MUL w_data=0x8F and MULH w_data=0x00; w_en occurs 9 cycles after start.
REQ-031 SHALL test MUL and MULH with rd=200, rs=3 -> MUL 0x58 and MULH 0x02, with w_addr equal to the dst_addr latched at start.
REQ-032 SHALL test DIV and MOD with rd=200, rs=7 -> DIV 0x1C and MOD 0x04.
REQ-033 SHALL test divide by zero with rd=0x55, rs=0 -> DIV 0xFF and MOD 0x55, with latency 9.
REQ-034 SHALL test start re-asserted with different operands during RUN -> ignored, original result written, and exactly one w_en pulse.
REQ-035 SHALL test reset asserted at RUN cycle 4 -> busy=0 immediately, no w_en, and a subsequent start completes normally.
